// File: rtl/bound_flasher_outfsm.sv
// Bound flasher output datapath: IDLE/RUN sequencer driving a 16-lamp thermometer bar.
// Optional macro BOUND_FLASHER_START_SYNC_EN adds a two-flop synchronizer on start.
module bound_flasher_outfsm #(
  parameter int PRESCALE  = 1,
  parameter int ZERO_HITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        up,
  output logic [4:0]  state_cnt,
  output logic        step_enb,
  output logic [15:0] lamps,
  output logic        busy,
  output logic        done
);

  localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [3:0]     HITS_END = 4'(ZERO_HITS);
  localparam logic [4:0]     CNT_MAX  = 5'd16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state, state_d;
  logic [4:0]    cnt, cnt_d;
  logic [PW-1:0] pre, pre_d;
  logic [3:0]    hits, hits_d;
  logic          done_q, done_d;
  logic          start_seen;

`ifdef BOUND_FLASHER_START_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], start};
    end
  end

  assign start_seen = sync_q[1];
`else
  assign start_seen = start;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values of the previous cycle, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      pre    <= '0;
      hits   <= 4'd0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      pre    <= pre_d;
      hits   <= hits_d;
      done_q <= done_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    pre_d    = pre;
    hits_d   = hits;
    done_d   = 1'b0;
    step_enb = (state == RUN) && (pre == PRE_LAST);

    case (state)
      IDLE: begin
        if (start_seen) begin
          state_d = RUN;
          cnt_d   = 5'd0;
          pre_d   = '0;
          hits_d  = 4'd0;
        end
      end
      RUN: begin
        pre_d = step_enb ? '0 : pre + PW'(1);
        if (step_enb) begin
          if (up) begin
            if (cnt != CNT_MAX) cnt_d = cnt + 5'd1;
          end else if (cnt != 5'd0) begin
            cnt_d = cnt - 5'd1;
            // Only a real 1 -> 0 arrival counts; idling at zero does not.
            if (cnt == 5'd1) begin
              hits_d = hits + 4'd1;
              if (hits + 4'd1 == HITS_END) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lamps = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      lamps[i] = (5'(i) < cnt);
    end
  end

  assign state_cnt = cnt;
  assign busy      = (state == RUN);
  assign done      = done_q;

endmodule

// File: tb/tb_bound_flasher_outfsm.sv
// Self-checking bench for bound_flasher_outfsm: a PRESCALE=1 and a PRESCALE=3 instance
// checked every cycle against a lamp-count model, plus vector table and corner sequences.
module tb_bound_flasher_outfsm;

`ifdef BOUND_FLASHER_START_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int ZH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, up1, start3, up3;
  logic [4:0]  state_cnt1, state_cnt3;
  logic [15:0] lamps1, lamps3;
  logic        step_enb1, step_enb3, busy1, busy3, done1, done3;

  int errors = 0;
  int checks = 0;
  int done_seen1 = 0;

  bound_flasher_outfsm #(.PRESCALE(1), .ZERO_HITS(ZH)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .up(up1),
    .state_cnt(state_cnt1), .step_enb(step_enb1), .lamps(lamps1),
    .busy(busy1), .done(done1)
  );

  bound_flasher_outfsm #(.PRESCALE(3), .ZERO_HITS(ZH)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .up(up3),
    .state_cnt(state_cnt3), .step_enb(step_enb3), .lamps(lamps3),
    .busy(busy3), .done(done3)
  );

  always #5 clk = ~clk;

  // Reference model: lit-lamp count, cycle phase inside a step, zero arrivals.
  int m_run[2], m_cnt[2], m_phase[2], m_hits[2], m_done[2], m_hist[2];
  int m_pres[2] = '{1, 3};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] bar(input int n);
    logic [31:0] ones;
    ones = (32'd1 << n) - 32'd1;
    return ones[15:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_cnt[k] = 0; m_phase[k] = 0;
      m_hits[k] = 0; m_done[k] = 0; m_hist[k] = 0;
    end
  endtask

  task automatic model_advance(input int k, input bit s, input bit u);
    bit seen;
    int nd;
    seen = (LAT == 0) ? s : bit'((m_hist[k] >> (LAT - 1)) & 1);
    m_hist[k] = ((m_hist[k] << 1) | int'(s)) & 3;
    nd = 0;
    if (m_run[k] == 0) begin
      if (seen) begin
        m_run[k] = 1; m_cnt[k] = 0; m_phase[k] = 0; m_hits[k] = 0;
      end
    end else if (m_phase[k] == m_pres[k] - 1) begin
      m_phase[k] = 0;
      if (u) begin
        m_cnt[k] = (m_cnt[k] < 16) ? m_cnt[k] + 1 : 16;
      end else if (m_cnt[k] > 0) begin
        m_cnt[k]--;
        if (m_cnt[k] == 0) begin
          m_hits[k]++;
          if (m_hits[k] == ZH) begin
            m_run[k] = 0;
            nd = 1;
          end
        end
      end
    end else begin
      m_phase[k]++;
    end
    m_done[k] = nd;
  endtask

  task automatic compare_model();
    check("p1_cnt",   32'(state_cnt1), 32'(m_cnt[0]));
    check("p1_lamps", 32'(lamps1),     32'(bar(m_cnt[0])));
    check("p1_busy",  32'(busy1),      32'(m_run[0]));
    check("p1_step",  32'(step_enb1),  32'(m_run[0] != 0 && m_phase[0] == 0));
    check("p1_done",  32'(done1),      32'(m_done[0]));
    check("p3_cnt",   32'(state_cnt3), 32'(m_cnt[1]));
    check("p3_lamps", 32'(lamps3),     32'(bar(m_cnt[1])));
    check("p3_busy",  32'(busy3),      32'(m_run[1]));
    check("p3_step",  32'(step_enb3),  32'(m_run[1] != 0 && m_phase[1] == 2));
    check("p3_done",  32'(done3),      32'(m_done[1]));
  endtask

  // Drive inputs just after a rising edge, then sample at the falling edge.
  task automatic drive(input bit s1, input bit u1, input bit s3, input bit u3);
    start1 = s1; up1 = u1; start3 = s3; up3 = u3;
    @(negedge clk);
    compare_model();
    if (done1) done_seen1++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      model_advance(0, start1, up1);
      model_advance(1, start3, up3);
    end
    #1;
  endtask

  task automatic cyc(input bit s1, input bit u1, input bit s3, input bit u3);
    drive(s1, u1, s3, u3);
    tick();
  endtask

  task automatic steps1(input int n, input bit d);
    repeat (n) cyc(1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic start_run(input int k, output int edges);
    edges = 0;
    cyc(k == 0, 1'b0, k == 1, 1'b0);
    for (int n = 0; n < 8; n++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      if ((k == 0) ? busy1 : busy3) begin
        edges = n + 1;
        tick();
        break;
      end
      tick();
    end
    check("start_timeout", 32'(edges != 0), 32'd1);
  endtask

  task automatic reset_mid();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_cnt",   32'(state_cnt1), 32'd0);
    check("rst_lamps", 32'(lamps1),     32'd0);
    check("rst_busy",  32'(busy1),      32'd0);
    check("rst_step",  32'(step_enb1),  32'd0);
    check("rst_done",  32'(done1),      32'd0);
    tick();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  typedef struct {
    bit          s;
    bit          u;
    int          cnt;
    bit          busy;
    bit          step;
    logic [15:0] lamps;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int edges, done_before, nsteps;

    for (int i = 0; i <= LAT; i++) tbl.push_back('{1'b1, 1'b1, 0, 1'b0, 1'b0, 16'h0000});
    for (int c = 0; c <= 6; c++)   tbl.push_back('{1'b0, 1'b1, c, 1'b1, 1'b1, bar(c)});

    rst = 1'b1;
    start1 = 0; up1 = 0; start3 = 0; up3 = 0;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("init_lamps", 32'(lamps1), 32'h0);
    check("init_busy",  32'(busy3),  32'h0);
    tick();
    rst = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 1'b1);

    // Up ramp from a start pulse: one lamp per cycle, ending at 16'h003F.
    foreach (tbl[i]) begin
      drive(tbl[i].s, tbl[i].u, 1'b0, 1'b0);
      check("tbl_cnt",   32'(state_cnt1), 32'(tbl[i].cnt));
      check("tbl_busy",  32'(busy1),      32'(tbl[i].busy));
      check("tbl_step",  32'(step_enb1),  32'(tbl[i].step));
      check("tbl_lamps", 32'(lamps1),     32'(tbl[i].lamps));
      tick();
    end

    reset_mid();

    // Full profile 0->6->0->11->5->16->0: one done pulse after the second arrival.
    start_run(0, edges);
    check("busy_rise_edges", 32'(edges), 32'(1 + LAT));
    done_before = done_seen1;
    steps1(6, 1'b1); steps1(6, 1'b0);
    check("mid_busy_after_hit1", 32'(busy1), 32'd1);
    steps1(11, 1'b1); steps1(6, 1'b0); steps1(11, 1'b1);
    check("peak_lamps", 32'(lamps1), 32'hFFFF);
    steps1(16, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("seq_done", 32'(done1), 32'd1);
    check("seq_busy", 32'(busy1), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("seq_done_len", 32'(done1), 32'd0);
    tick();
    check("seq_done_count", 32'(done_seen1 - done_before), 32'd1);

    // Saturation at 16 and no hit while parked at 0.
    start_run(0, edges);
    steps1(20, 1'b1);
    check("sat_cnt",   32'(state_cnt1), 32'd16);
    check("sat_lamps", 32'(lamps1),     32'hFFFF);
    steps1(16, 1'b0);
    steps1(5, 1'b0);
    check("zero_no_hit_busy", 32'(busy1), 32'd1);
    steps1(1, 1'b1); steps1(1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("sat_done", 32'(done1), 32'd1);
    tick();

    // Start held through done restarts immediately; then abort at cnt=9.
    start_run(0, edges);
    steps1(3, 1'b1); steps1(3, 1'b0); steps1(2, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("held_done", 32'(done1), 32'd1);
    check("held_idle", 32'(busy1), 32'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("held_restart_busy", 32'(busy1),      32'd1);
    check("held_restart_cnt",  32'(state_cnt1), 32'd0);
    tick();
    steps1(9, 1'b1);
    check("abort_cnt", 32'(state_cnt1), 32'd9);
    reset_mid();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("abort_no_done", 32'(done1), 32'd0);
      check("abort_idle",    32'(busy1), 32'd0);
      tick();
    end

    // PRESCALE=3: a step every third cycle, up ignored between steps.
    start_run(1, edges);
    nsteps = 0;
    for (int i = 0; i < 30; i++) begin
      drive(1'b0, 1'b0, 1'b0, (i % 3 == 1) ? 1'b1 : bit'($urandom_range(0, 1)));
      if (step_enb3) nsteps++;
      tick();
    end
    check("pre3_steps", 32'(nsteps), 32'd10);
    check("pre3_cnt",   32'(state_cnt3), 32'd10);

    // Random traffic on both instances against the model.
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 7) == 0, bit'($urandom_range(0, 1)),
          $urandom_range(0, 7) == 0, bit'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
